// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration controller:
// the controller FSM encoding and the out-of-reset half-period count.
package div_ctrl_pkg;

  // 50 MHz system clock divided to 1 MHz.
  localparam int DEFAULT_HALF = 25;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    DONE      = 2'd2
  } state_t;

endpackage

// File: rtl/div_core.sv
// Counter/toggle datapath of the divider. Counts 0..half-1 per phase,
// toggles clk_out at the wrap and flags the last cycle of a full period
// (high phase ending) so the controller can switch half-periods cleanly.
module div_core #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] half,
  input  logic                 load,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 at_period_end
);

  logic [DIV_WIDTH-1:0] counter;
  logic                 at_count_end;

  // >= rather than == so a counter can never run past a shortened limit.
  assign at_count_end  = (counter >= (half - DIV_WIDTH'(1)));
  assign at_period_end = enable && clk_out && at_count_end;

  // Phase counter and output register; disable or load restarts a clean low phase.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      counter <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!enable || load) begin
      counter <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (at_count_end) begin
      counter <= '0;
      clk_out <= ~clk_out;
      tick    <= ~clk_out;
    end else begin
      counter <= counter + DIV_WIDTH'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/div_config_ctrl.sv
// Clock divider with a two-requester configuration port. A new half-period
// is accepted only in IDLE, held in a pending register, and applied at the
// end of a full output period (or at once while the divider is stopped), so
// clk_out never shows a phase shorter than the old or new half-period.
module div_config_ctrl #(
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_HALF = div_ctrl_pkg::DEFAULT_HALF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 req0_valid,
  input  logic [DIV_WIDTH-1:0] req0_half,
  input  logic                 req1_valid,
  input  logic [DIV_WIDTH-1:0] req1_half,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic                 clk_out,
  output logic                 tick,
  output logic [DIV_WIDTH-1:0] cur_half,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  import div_ctrl_pkg::*;

  localparam logic [DIV_WIDTH-1:0] RESET_HALF = DIV_WIDTH'(DEFAULT_HALF);

  state_t               state, state_nxt;
  logic                 rr_ptr;
  logic                 gnt;
  logic                 xfer;
  logic [DIV_WIDTH-1:0] xfer_half;
  logic [DIV_WIDTH-1:0] pending;
  logic                 apply;
  logic                 at_period_end;

  assign xfer      = req0_ready || req1_ready;
  assign xfer_half = gnt ? req1_half : req0_half;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Arbitration, handshake and next-state decode.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    apply      = 1'b0;
    gnt        = rr_ptr;
    if (req0_valid && !req1_valid) gnt = 1'b0;
    if (req1_valid && !req0_valid) gnt = 1'b1;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !gnt;
        req1_ready = req1_valid && gnt;
        if ((req0_ready || req1_ready) && (xfer_half != '0)) state_nxt = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (!enable || at_period_end) begin
          apply     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Config datapath: rr pointer, pending/active half-periods, error pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      pending  <= RESET_HALF;
      cur_half <= RESET_HALF;
      err      <= 1'b0;
    end else begin
      err <= xfer && (xfer_half == '0);
      if (xfer && (xfer_half != '0)) pending <= xfer_half;
      // Only a contested transfer moves the pointer.
      if (xfer && req0_valid && req1_valid) rr_ptr <= ~rr_ptr;
      if (apply) cur_half <= pending;
    end
  end

  div_core #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_core (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .half         (cur_half),
    .load         (apply),
    .clk_out      (clk_out),
    .tick         (tick),
    .at_period_end(at_period_end)
  );

endmodule

// File: tb/tb_div_config_ctrl.sv
// Scoreboard bench for div_config_ctrl: stimulus queues feed a requester
// process; a negedge monitor predicts arbitration, pulses and phase lengths.
module tb_div_config_ctrl;

  localparam int W   = 16;
  localparam int DEF = 25;

  typedef struct packed {
    logic         is_err;
    logic [W-1:0] half;
  } exp_t;

  logic         clk_in = 1'b0;
  logic         reset, enable;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_half, req1_half;
  logic         req0_ready, req1_ready;
  logic         clk_out, tick, busy, done, err;
  logic [W-1:0] cur_half;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  exp_t         sb_q[$];

  always #5 clk_in = ~clk_in;

  div_config_ctrl #(.DIV_WIDTH(W), .DEFAULT_HALF(DEF)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .req0_valid(req0_valid), .req0_half(req0_half),
    .req1_valid(req1_valid), .req1_half(req1_half),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .clk_out(clk_out), .tick(tick), .cur_half(cur_half),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Requesters: hold valid until accepted, then take the next queued value.
  logic acc0, acc1;
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; req0_half = '0; req1_half = '0;
    forever begin
      @(negedge clk_in);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk_in); #1;
      if (reset) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else begin
        if (!req0_valid || acc0) begin
          if (q0.size() > 0) begin req0_half = q0.pop_front(); req0_valid = 1'b1; end
          else req0_valid = 1'b0;
        end
        if (!req1_valid || acc1) begin
          if (q1.size() > 0) begin req1_half = q1.pop_front(); req1_valid = 1'b1; end
          else req1_valid = 1'b0;
        end
      end
    end
  end

  // Reference model + monitor.
  bit           m_inflight, m_ptr, phase_ok, prev_clk;
  int           m_half, m_wait, phase_len, phase_half;
  logic         exp_r0, exp_r1;
  logic [W-1:0] h;
  exp_t         e;

  always @(negedge clk_in) begin
    if (reset) begin
      sb_q.delete();
      m_inflight = 0; m_ptr = 0; m_half = DEF; m_wait = 0;
      prev_clk = 0; phase_ok = 0; phase_len = 0; phase_half = DEF;
    end else begin
      if (done || err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, done, err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_is_err", err, e.is_err);
          check("pulse_is_done", done, !e.is_err);
          if (!e.is_err) begin
            check("done_cur_half", cur_half, e.half);
            check("done_clk_out_low", clk_out, 1'b0);
            m_half = e.half;
          end else begin
            check("err_cur_half_kept", cur_half, m_half);
          end
        end
      end
      check("busy", busy, m_inflight);
      exp_r0 = 1'b0; exp_r1 = 1'b0;
      if (!m_inflight) begin
        if (req0_valid && (!req1_valid || !m_ptr)) exp_r0 = 1'b1;
        else if (req1_valid) exp_r1 = 1'b1;
      end
      check("req0_ready", req0_ready, exp_r0);
      check("req1_ready", req1_ready, exp_r1);
      if (done) begin m_inflight = 0; m_wait = 0; end
      if (exp_r0 || exp_r1) begin
        h = exp_r0 ? req0_half : req1_half;
        sb_q.push_back('{is_err: (h == '0), half: h});
        if (h != '0) m_inflight = 1;
        if (req0_valid && req1_valid) m_ptr = ~m_ptr;
      end
      if (m_inflight) begin
        m_wait++;
        if (m_wait > 80) begin
          checks++; failures++;
          $display("FAIL apply_timeout: waited %0d cycles, limit 80", m_wait);
          m_inflight = 0; m_wait = 0; sb_q.delete();
        end
      end
      check("tick", tick, clk_out && !prev_clk);
      if (clk_out !== prev_clk) begin
        if (phase_ok) check("phase_len", phase_len, phase_half);
        phase_len = 1; phase_half = m_half; phase_ok = enable;
      end else begin
        phase_len++;
        if (!enable) phase_ok = 0;
      end
      prev_clk = clk_out;
    end
  end

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (!(!busy && sb_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
             !req0_valid && !req1_valid) && n < budget) begin
      @(negedge clk_in); n++;
    end
    check("quiet_within_budget", n < budget, 1'b1);
    @(posedge clk_in); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  n, lat;
  bit  saw_done;

  initial begin
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_cur_half", cur_half, DEF);
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_tick", tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk_in); #1;
    reset = 1'b0; enable = 1'b1;

    // Default divide: 25-cycle phases.
    cycles(130);
    check("default_cur_half", cur_half, DEF);

    // Single request mid high phase.
    n = 0;
    while (!tick && n < 100) begin @(negedge clk_in); n++; end
    check("saw_rise", tick, 1'b1);
    repeat (5) @(negedge clk_in);
    q0.push_back(W'(10));
    wait_quiet(200);
    cycles(60);
    check("cur_half_10", cur_half, 10);

    // Contested pairs: req0 first, then req1 first.
    q0.push_back(W'(8)); q1.push_back(W'(12));
    wait_quiet(300);
    check("pair1_cur_half", cur_half, 12);
    q0.push_back(W'(6)); q1.push_back(W'(9));
    wait_quiet(300);
    check("pair2_cur_half", cur_half, 6);

    // Zero half-period is rejected.
    q1.push_back(W'(0));
    wait_quiet(50);
    check("zero_keeps_half", cur_half, 6);

    // Stopped divider applies immediately.
    enable = 1'b0;
    cycles(3);
    q0.push_back(W'(5));
    n = 0;
    do begin @(negedge clk_in); n++; end while (!(req0_valid && req0_ready) && n < 10);
    lat = 0;
    do begin @(negedge clk_in); lat++; end while (!done && lat < 6);
    check("disabled_done_latency", lat, 2);
    check("disabled_clk_out", clk_out, 1'b0);
    wait_quiet(20);
    check("cur_half_5", cur_half, 5);
    enable = 1'b1;
    cycles(40);

    // Reset during WAIT_EDGE discards the pending value.
    q0.push_back(W'(7));
    n = 0;
    do begin @(negedge clk_in); n++; end while (!(busy && !done) && n < 20);
    check("reached_wait_edge", busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(negedge clk_in);
    check("post_reset_half", cur_half, DEF);
    saw_done = 0;
    repeat (30) begin @(negedge clk_in); if (done) saw_done = 1; end
    check("no_done_after_reset", saw_done, 1'b0);
    @(posedge clk_in); #1;
    q1.push_back(W'(3));
    wait_quiet(200);
    check("resume_cur_half", cur_half, 3);

    // Randomized traffic with enable toggling.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk_in); #1;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0 && q0.size() < 2) q0.push_back(W'($urandom_range(0, 12)));
      if ($urandom_range(0, 19) == 0 && q1.size() < 2) q1.push_back(W'($urandom_range(0, 12)));
    end
    enable = 1'b1;
    wait_quiet(2000);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_config_ctrl.md
DIV_CONFIG_CTRL -- requirements
Module: div_config_ctrl

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of half-period count values.
REQ-002 SHALL have parameter DEFAULT_HALF, default 25, active half-period count out of reset (50 MHz -> 1 MHz).
REQ-003 SHALL have port clk_in  input  1  system clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  divider run enable.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester N offers a new half-period.
REQ-007 SHALL have ports req0_half / req1_half  input  DIV_WIDTH  requested half-period count.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle (combinational).
REQ-009 SHALL have port clk_out  output  1  divided clock (register output).
REQ-010 SHALL have port tick  output  1  one-cycle pulse on each clk_out 0->1 transition.
REQ-011 SHALL have port cur_half  output  DIV_WIDTH  active half-period count.
REQ-012 SHALL have port busy  output  1  high while state != IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a new value takes effect.
REQ-014 SHALL have port err  output  1  one-cycle pulse when an accepted value is rejected.

Function
REQ-015 Divider SHALL count 0..cur_half-1 while enable=1; at cur_half-1 counter wraps to 0 and clk_out toggles; tick=1 in the cycle clk_out is registered 0->1.
REQ-016 With enable=0, counter and clk_out SHALL be forced to 0 on the next edge; tick=0.
REQ-017 FSM states SHALL be IDLE, WAIT_EDGE, DONE.
REQ-018 In IDLE only, readyN=1 when reqN_valid=1 and N holds the grant; transfer occurs when validN & readyN.
REQ-019 Arbitration: single valid requester wins; both valid -> round-robin pointer wins, pointer then moves to the other requester; pointer updates only on a transfer.
REQ-020 On transfer with half=0: value discarded, err=1 next cycle, state stays IDLE, cur_half unchanged.
REQ-021 On transfer with half>=1: value latched into pending register, state -> WAIT_EDGE.
REQ-022 WAIT_EDGE with enable=1: apply in the cycle where counter==cur_half-1 and clk_out==1 (end of full period): cur_half<=pending, counter<=0, clk_out<=0; state -> DONE.
REQ-023 WAIT_EDGE with enable=0: apply on the next edge without waiting; state -> DONE.
REQ-024 DONE: done=1 for exactly that cycle; state -> IDLE next edge; readyN=0 throughout WAIT_EDGE and DONE.
REQ-025 Requests arriving while busy SHALL be held off (ready=0), never dropped or queued internally.
REQ-026 clk_out SHALL never produce a high or low phase shorter than min(old, new) half-period counts (glitch-free switch).
REQ-027 enable deasserting mid WAIT_EDGE SHALL fall into REQ-023 behaviour.

Reset
REQ-028 reset SHALL asynchronously set: counter=0, clk_out=0, tick=0, cur_half=DEFAULT_HALF, pending=DEFAULT_HALF, state=IDLE, rr pointer=requester 0, done=0, err=0.
REQ-029 reset during WAIT_EDGE SHALL discard the pending value; no done pulse after release.

Structure
REQ-030 FSM state encoding and DEFAULT_HALF SHALL live in shared package div_ctrl_pkg.
REQ-031 Counter/toggle datapath SHALL be sub-module div_core (inputs enable, half, load; outputs clk_out, tick, at_period_end); arbiter and FSM stay in top.

Verification
REQ-032 Reset release, enable=1, no requests -> clk_out toggles every 25 cycles, tick every 50 cycles, cur_half=25.
REQ-033 req0_valid=1, half=10 mid high phase -> ready0 pulses 1 cycle, busy=1, switch at period end, done pulse, subsequent half-periods exactly 10 cycles, no short phase.
REQ-034 req0 and req1 valid same cycle (half 8 and 12) -> req0 served first (done, cur_half=8), then req1 (cur_half=12); next simultaneous pair -> req1 first.
REQ-035 req1_valid=1, half=0 -> ready1 pulse, err=1 one cycle later, cur_half unchanged, busy stays 0.
REQ-036 enable=0, request half=5 -> done within 2 cycles, cur_half=5, clk_out=0; enable=1 -> 5-cycle half-periods.
REQ-037 reset asserted in WAIT_EDGE with pending=7 -> after release cur_half=25, no done, req ready resumes in IDLE.
